// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry
// defaults, address field widths and FSM state encodings.
package icache_pkg;

    localparam int ICACHE_LINE_NUM = 16;   // default number of lines
    localparam int LINE_BYTES      = 64;   // matches the memory fetch burst
    localparam int LINE_W          = 512;  // bits per line
    localparam int ADDR_W          = 32;
    localparam int OFFSET_W        = 6;    // log2(LINE_BYTES)
    localparam int INDEX_W_DEF     = $clog2(ICACHE_LINE_NUM);
    localparam int TAG_W_DEF       = ADDR_W - OFFSET_W - INDEX_W_DEF;

    // Index width for a given line count (line count is a power of two).
    function automatic int index_w(input int line_num);
        return $clog2(line_num);
    endfunction

    // Tag width is whatever remains above offset and index.
    function automatic int tag_w(input int line_num);
        return ADDR_W - OFFSET_W - $clog2(line_num);
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MISS = 2'd1,
        FILL = 2'd2
    } state_t;

endpackage

// File: rtl/icache_word_sel.sv
// Picks the little-endian 32-bit word starting at a byte offset inside a
// 512-bit line. Bytes past the end of the line wrap to the line start.
module icache_word_sel
    import icache_pkg::*;
(
    input  logic [LINE_W-1:0]   line,
    input  logic [OFFSET_W-1:0] byte_off,
    output logic [31:0]         word
);

    // Gather four consecutive bytes, lowest address in the lowest byte lane.
    always_comb begin
        logic [OFFSET_W-1:0] idx;
        word = '0;
        idx  = '0;
        for (int k = 0; k < 4; k++) begin
            idx = byte_off + OFFSET_W'(k);
            word[k*8 +: 8] = line[{idx, 3'b000} +: 8];
        end
    end

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache with single outstanding line fill.
// Optional feature macro: ICACHE_PERF_EN adds hit_cnt / miss_cnt outputs.
//
// Fill handshake: mem_if_en is a request held high (with mem_if_pc stable)
// until the controller answers with a one-cycle mem_if_done pulse carrying
// mem_if_data; mem_if_en drops on the following edge, so a request is seen
// exactly once. rdy low freezes every register, including the handshake.
module icache
    import icache_pkg::*;
#(
    parameter int LINE_NUM = ICACHE_LINE_NUM
)
(
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              rollback,
    input  logic              fetch_en,
    input  logic [31:0]       fetch_pc,
    output logic              inst_valid,
    output logic [31:0]       inst_data,
    output logic [31:0]       inst_pc,
    output logic              mem_if_en,
    output logic [31:0]       mem_if_pc,
    input  logic [LINE_W-1:0] mem_if_data,
    input  logic              mem_if_done,
`ifdef ICACHE_PERF_EN
    output logic [31:0]       hit_cnt,
    output logic [31:0]       miss_cnt,
`endif
    output state_t            state_dbg
);

    localparam int INDEX_W = index_w(LINE_NUM);
    localparam int TAG_W   = tag_w(LINE_NUM);

    state_t              state, state_d;
    logic [LINE_NUM-1:0] valid_q;
    logic [TAG_W-1:0]    tag_q  [LINE_NUM];
    logic [LINE_W-1:0]   data_q [LINE_NUM];
    logic [31:0]         miss_pc, miss_pc_d;
    logic                rb_pending, rb_pending_d;
    logic                inst_valid_d, mem_if_en_d, fill_we;
    logic [31:0]         inst_data_d, inst_pc_d, mem_if_pc_d;

    logic [INDEX_W-1:0]  req_index, miss_index;
    logic [TAG_W-1:0]    req_tag, miss_tag;
    logic                hit;
    logic [LINE_W-1:0]   sel_line;
    logic [OFFSET_W-1:0] sel_off;
    logic [31:0]         sel_word;

    assign req_index  = fetch_pc[OFFSET_W +: INDEX_W];
    assign req_tag    = fetch_pc[ADDR_W-1 -: TAG_W];
    assign miss_index = miss_pc[OFFSET_W +: INDEX_W];
    assign miss_tag   = miss_pc[ADDR_W-1 -: TAG_W];
    assign hit        = valid_q[req_index] && (tag_q[req_index] == req_tag);
    assign state_dbg  = state;

    // Word lookup: the request line in IDLE, the freshly filled line in FILL.
    // The low two pc bits are dropped so only aligned words are returned.
    always_comb begin
        sel_line = data_q[req_index];
        sel_off  = {fetch_pc[OFFSET_W-1:2], 2'b00};
        if (state == FILL) begin
            sel_line = data_q[miss_index];
            sel_off  = {miss_pc[OFFSET_W-1:2], 2'b00};
        end
    end

    icache_word_sel u_word_sel (
        .line     (sel_line),
        .byte_off (sel_off),
        .word     (sel_word)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        inst_valid_d = 1'b0;
        inst_data_d  = inst_data;
        inst_pc_d    = inst_pc;
        mem_if_en_d  = mem_if_en;
        mem_if_pc_d  = mem_if_pc;
        miss_pc_d    = miss_pc;
        rb_pending_d = rb_pending;
        fill_we      = 1'b0;
        case (state)
            IDLE: begin
                if (fetch_en && !rollback) begin
                    if (hit) begin
                        inst_valid_d = 1'b1;
                        inst_data_d  = sel_word;
                        inst_pc_d    = fetch_pc;
                    end else begin
                        state_d      = MISS;
                        mem_if_en_d  = 1'b1;
                        mem_if_pc_d  = {fetch_pc[31:OFFSET_W], {OFFSET_W{1'b0}}};
                        miss_pc_d    = fetch_pc;
                        rb_pending_d = 1'b0;
                    end
                end
            end
            MISS: begin
                // A flush during the fill does not cancel it; it only mutes
                // the eventual response.
                if (rollback) rb_pending_d = 1'b1;
                if (mem_if_done) begin
                    fill_we     = 1'b1;
                    mem_if_en_d = 1'b0;
                    state_d     = FILL;
                end
            end
            FILL: begin
                // A flush arriving in FILL itself also mutes the response.
                if (!rb_pending && !rollback) begin
                    inst_valid_d = 1'b1;
                    inst_data_d  = sel_word;
                    inst_pc_d    = miss_pc;
                end
                rb_pending_d = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; rdy low holds everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            inst_valid <= 1'b0;
            inst_data  <= '0;
            inst_pc    <= '0;
            mem_if_en  <= 1'b0;
            mem_if_pc  <= '0;
            miss_pc    <= '0;
            rb_pending <= 1'b0;
        end else if (rdy) begin
            state      <= state_d;
            inst_valid <= inst_valid_d;
            inst_data  <= inst_data_d;
            inst_pc    <= inst_pc_d;
            mem_if_en  <= mem_if_en_d;
            mem_if_pc  <= mem_if_pc_d;
            miss_pc    <= miss_pc_d;
            rb_pending <= rb_pending_d;
        end
    end

    // Valid bits: cleared by reset, set when a fill lands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (rdy && fill_we) begin
            valid_q[miss_index] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; valid_q guards them.
    always_ff @(posedge clk) begin
        if (rdy && fill_we) begin
            tag_q[miss_index]  <= miss_tag;
            data_q[miss_index] <= mem_if_data;
        end
    end

`ifdef ICACHE_PERF_EN
    logic hit_evt, miss_evt;
    assign hit_evt  = (state == IDLE) && fetch_en && !rollback && hit;
    assign miss_evt = (state == IDLE) && fetch_en && !rollback && !hit;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (rdy) begin
            if (hit_evt)  hit_cnt  <= hit_cnt + 32'd1;
            if (miss_evt) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache (LINE_NUM = 16). Inputs change and outputs are
// sampled 1 ns after each rising edge.
module tb_icache;
    import icache_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rdy = 1'b1;
    logic          rollback = 1'b0;
    logic          fetch_en = 1'b0;
    logic [31:0]   fetch_pc = '0;
    logic          inst_valid;
    logic [31:0]   inst_data, inst_pc;
    logic          mem_if_en;
    logic [31:0]   mem_if_pc;
    logic [511:0]  mem_if_data = '0;
    logic          mem_if_done = 1'b0;
    state_t        state_dbg;
`ifdef ICACHE_PERF_EN
    logic [31:0]   hit_cnt, miss_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    icache #(.LINE_NUM(16)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .rollback(rollback),
        .fetch_en(fetch_en), .fetch_pc(fetch_pc),
        .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
        .mem_if_en(mem_if_en), .mem_if_pc(mem_if_pc),
        .mem_if_data(mem_if_data), .mem_if_done(mem_if_done),
`ifdef ICACHE_PERF_EN
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt),
`endif
        .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [511:0] mk_line(input logic [7:0] base);
        logic [511:0] l;
        for (int i = 0; i < 64; i++) l[i*8 +: 8] = base + 8'(i);
        return l;
    endfunction

    task automatic fetch(input logic [31:0] pc);
        fetch_en = 1'b1;
        fetch_pc = pc;
        tick();
        fetch_en = 1'b0;
    endtask

    task automatic fill(input logic [7:0] base);
        mem_if_data = mk_line(base);
        mem_if_done = 1'b1;
        tick();
        mem_if_done = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %0b want 0", inst_valid); end
        n_tests++; if (mem_if_en !== 1'b0) begin n_fail++; $display("FAIL reset_mem_if_en: got %0b want 0", mem_if_en); end
        n_tests++; if (mem_if_pc !== 32'h0) begin n_fail++; $display("FAIL reset_mem_if_pc: got %h want 0", mem_if_pc); end
        n_tests++; if (inst_data !== 32'h0 || inst_pc !== 32'h0) begin n_fail++; $display("FAIL reset_inst: data %h pc %h want 0 0", inst_data, inst_pc); end
        n_tests++; if (state_dbg !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want IDLE", state_dbg); end
    endtask

    task automatic test_cold_read();
        fetch(32'h0000_1004);
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL cold_req: en %0b pc %h want 1 00001000", mem_if_en, mem_if_pc); end
        n_tests++; if (state_dbg !== MISS || inst_valid !== 1'b0) begin n_fail++; $display("FAIL cold_miss_state: state %0d valid %0b want MISS 0", state_dbg, inst_valid); end
        tick();
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL cold_req_hold: en %0b pc %h want 1 00001000", mem_if_en, mem_if_pc); end
        fill(8'h00);
        n_tests++; if (mem_if_en !== 1'b0 || inst_valid !== 1'b0 || state_dbg !== FILL) begin n_fail++; $display("FAIL cold_fill: en %0b valid %0b state %0d want 0 0 FILL", mem_if_en, inst_valid, state_dbg); end
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h0706_0504 || inst_pc !== 32'h0000_1004) begin n_fail++; $display("FAIL cold_resp: valid %0b data %h pc %h want 1 07060504 00001004", inst_valid, inst_data, inst_pc); end
        tick();
        n_tests++; if (inst_valid !== 1'b0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL cold_pulse: valid %0b state %0d want 0 IDLE", inst_valid, state_dbg); end
    endtask

    task automatic test_hit();
        fetch(32'h0000_1008);
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h0B0A_0908 || inst_pc !== 32'h0000_1008) begin n_fail++; $display("FAIL hit_resp: valid %0b data %h pc %h want 1 0b0a0908 00001008", inst_valid, inst_data, inst_pc); end
        n_tests++; if (mem_if_en !== 1'b0) begin n_fail++; $display("FAIL hit_no_mem: got %0b want 0", mem_if_en); end
        // low pc bits are ignored for the word but reported in inst_pc
        fetch(32'h0000_103F);
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h3F3E_3D3C || inst_pc !== 32'h0000_103F) begin n_fail++; $display("FAIL hit_last_word: valid %0b data %h pc %h want 1 3f3e3d3c 0000103f", inst_valid, inst_data, inst_pc); end
        tick();
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL hit_pulse: got %0b want 0", inst_valid); end
    endtask

    task automatic test_back_to_back();
        fetch_en = 1'b1; fetch_pc = 32'h0000_1010;
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h1312_1110) begin n_fail++; $display("FAIL b2b_first: valid %0b data %h want 1 13121110", inst_valid, inst_data); end
        fetch_pc = 32'h0000_1020;
        tick();
        fetch_en = 1'b0;
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h2322_2120 || inst_pc !== 32'h0000_1020) begin n_fail++; $display("FAIL b2b_second: valid %0b data %h pc %h want 1 23222120 00001020", inst_valid, inst_data, inst_pc); end
    endtask

    task automatic test_conflict();
        fetch(32'h0000_1400);
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_1400) begin n_fail++; $display("FAIL conflict_req: en %0b pc %h want 1 00001400", mem_if_en, mem_if_pc); end
        fill(8'h80);
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h8382_8180 || inst_pc !== 32'h0000_1400) begin n_fail++; $display("FAIL conflict_resp: valid %0b data %h pc %h want 1 83828180 00001400", inst_valid, inst_data, inst_pc); end
        fetch(32'h0000_1004);
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_1000 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL conflict_evict: en %0b pc %h valid %0b want 1 00001000 0", mem_if_en, mem_if_pc, inst_valid); end
        fill(8'h00);
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h0706_0504) begin n_fail++; $display("FAIL conflict_refill: valid %0b data %h want 1 07060504", inst_valid, inst_data); end
    endtask

    task automatic test_rollback();
        // flush while idle: nothing serviced, no fill started
        rollback = 1'b1;
        fetch(32'h0000_1004);
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rb_idle_hit: valid %0b want 0", inst_valid); end
        fetch(32'h0000_5000);
        rollback = 1'b0;
        n_tests++; if (mem_if_en !== 1'b0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL rb_idle_miss: en %0b state %0d want 0 IDLE", mem_if_en, state_dbg); end
        // flush during MISS: fill completes, response muted
        fetch(32'h0000_2050);
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_2040) begin n_fail++; $display("FAIL rb_miss_req: en %0b pc %h want 1 00002040", mem_if_en, mem_if_pc); end
        rollback = 1'b1;
        tick();
        rollback = 1'b0;
        n_tests++; if (mem_if_en !== 1'b1) begin n_fail++; $display("FAIL rb_miss_keep: en %0b want 1", mem_if_en); end
        fill(8'h40);
        n_tests++; if (mem_if_en !== 1'b0) begin n_fail++; $display("FAIL rb_miss_drop: en %0b want 0", mem_if_en); end
        tick();
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rb_miss_muted: valid %0b want 0", inst_valid); end
        fetch(32'h0000_2050);
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h5352_5150 || mem_if_en !== 1'b0) begin n_fail++; $display("FAIL rb_refetch_hit: valid %0b data %h en %0b want 1 53525150 0", inst_valid, inst_data, mem_if_en); end
        // flush in the same cycle as mem_if_done
        fetch(32'h0000_3084);
        rollback = 1'b1;
        fill(8'hC0);
        rollback = 1'b0;
        tick();
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rb_done_muted: valid %0b want 0", inst_valid); end
        fetch(32'h0000_3084);
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'hC7C6_C5C4) begin n_fail++; $display("FAIL rb_done_installed: valid %0b data %h want 1 c7c6c5c4", inst_valid, inst_data); end
    endtask

    task automatic test_rdy();
        fetch(32'h0000_4100);
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_4100) begin n_fail++; $display("FAIL rdy_req: en %0b pc %h want 1 00004100", mem_if_en, mem_if_pc); end
        rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_4100 || state_dbg !== MISS) begin n_fail++; $display("FAIL rdy_hold_%0d: en %0b pc %h state %0d want 1 00004100 MISS", i, mem_if_en, mem_if_pc, state_dbg); end
        end
        rdy = 1'b1;
        fill(8'h10);
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h1312_1110 || inst_pc !== 32'h0000_4100) begin n_fail++; $display("FAIL rdy_resume: valid %0b data %h pc %h want 1 13121110 00004100", inst_valid, inst_data, inst_pc); end
        // a pending pulse stays up while rdy is low
        fetch(32'h0000_4104);
        rdy = 1'b0;
        tick(); tick(); tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h1716_1514) begin n_fail++; $display("FAIL rdy_pulse_held: valid %0b data %h want 1 17161514", inst_valid, inst_data); end
        rdy = 1'b1;
        tick();
        n_tests++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rdy_pulse_release: valid %0b want 0", inst_valid); end
    endtask

    task automatic test_reset_mid_miss();
        fetch(32'h0000_6200);
        n_tests++; if (mem_if_en !== 1'b1) begin n_fail++; $display("FAIL rst_mid_req: en %0b want 1", mem_if_en); end
        #2 rst = 1'b1;
        #1;
        n_tests++; if (mem_if_en !== 1'b0 || mem_if_pc !== 32'h0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_async: en %0b pc %h state %0d want 0 0 IDLE", mem_if_en, mem_if_pc, state_dbg); end
        tick();
        rst = 1'b0;
        fill(8'h20);
        n_tests++; if (mem_if_en !== 1'b0 || inst_valid !== 1'b0 || state_dbg !== IDLE) begin n_fail++; $display("FAIL rst_late_done: en %0b valid %0b state %0d want 0 0 IDLE", mem_if_en, inst_valid, state_dbg); end
        fetch(32'h0000_6200);
        n_tests++; if (mem_if_en !== 1'b1 || mem_if_pc !== 32'h0000_6200 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fresh_miss: en %0b pc %h valid %0b want 1 00006200 0", mem_if_en, mem_if_pc, inst_valid); end
        fill(8'h20);
        tick();
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h2322_2120) begin n_fail++; $display("FAIL rst_refill: valid %0b data %h want 1 23222120", inst_valid, inst_data); end
        // reset also dropped the older lines
        fetch(32'h0000_2050);
        n_tests++; if (mem_if_en !== 1'b1 || inst_valid !== 1'b0) begin n_fail++; $display("FAIL rst_cleared_line: en %0b valid %0b want 1 0", mem_if_en, inst_valid); end
        fill(8'h40);
        tick();
    endtask

    task automatic test_perf();
        do_reset();
`ifdef ICACHE_PERF_EN
        n_tests++; if (hit_cnt !== 32'd0 || miss_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_reset: hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); end
`endif
        fetch(32'h0000_1004);
        fill(8'h00);
        tick();
        fetch(32'h0000_1008);
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h0B0A_0908) begin n_fail++; $display("FAIL perf_hit1: valid %0b data %h want 1 0b0a0908", inst_valid, inst_data); end
        fetch(32'h0000_100C);
        n_tests++; if (inst_valid !== 1'b1 || inst_data !== 32'h0F0E_0D0C) begin n_fail++; $display("FAIL perf_hit2: valid %0b data %h want 1 0f0e0d0c", inst_valid, inst_data); end
`ifdef ICACHE_PERF_EN
        n_tests++; if (hit_cnt !== 32'd2 || miss_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_counts: hit %0d miss %0d want 2 1", hit_cnt, miss_cnt); end
`endif
    endtask

    // sequence and final report
    initial begin
        test_reset();
        test_cold_read();
        test_hit();
        test_back_to_back();
        test_conflict();
        test_rollback();
        test_rdy();
        test_reset_mid_miss();
        test_perf();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
